// File: rtl/spi_ram_burst_pkg.sv
// Shared types for the command-decoded SPI RAM: command encoding and transmit FSM states.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_HOLD = 1'b1
  } tx_state_e;

endpackage

// File: rtl/spi_ram_burst_if.sv
// Bus between the SPI slave and the RAM: receive words in, read data / handshake / debug out.
interface spi_ram_burst_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [DATA_W+1:0] din;
  logic              rx_valid;
  logic              tx_ready;
  logic              ovf_clr;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              ovf;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  // SPI side
  modport master (
    output din, rx_valid, tx_ready, ovf_clr,
    input  dout, tx_valid, ovf, wr_ptr, rd_ptr
  );

  // RAM side
  modport slave (
    input  din, rx_valid, tx_ready, ovf_clr,
    output dout, tx_valid, ovf, wr_ptr, rd_ptr
  );
endinterface

// File: rtl/spi_ram_burst_array.sv
// Single-port storage; addresses at or beyond MEM_DEPTH drop writes and read as zero.
module spi_ram_array #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  assign in_range = (32'(addr) < MEM_DEPTH);
  assign idx      = addr[IDX_W-1:0];

  // write port; out-of-range writes vanish instead of aliasing
  always_ff @(posedge clk) begin
    if (we && in_range) mem[idx] <= wdata;
  end

  assign rdata = in_range ? mem[idx] : '0;
endmodule

// File: rtl/spi_ram_burst.sv
// Command decoder, burst pointers, transmit hold handshake and sticky read-overrun flag.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 2**ADDR_W,
  parameter bit AUTO_INC  = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_ram_burst_if.slave bus
);
  cmd_e              cmd;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, addr;
  logic [DATA_W-1:0] rdata, dout;
  logic              rd_req, rd_fire, we, ovf;
  tx_state_e         state;

  assign cmd     = cmd_e'(bus.din[DATA_W+1:DATA_W]);
  assign payload = bus.din[DATA_W-1:0];

  // a read is refused only when the previous word is still held and not being taken
  assign rd_req  = bus.rx_valid && (cmd == CMD_RD_DATA);
  assign rd_fire = rd_req && ((state == TX_IDLE) || bus.tx_ready);
  assign we      = bus.rx_valid && (cmd == CMD_WR_DATA);
  assign addr    = we ? wr_ptr : rd_ptr;

  spi_ram_array #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)
  ) u_array (
    .clk(clk), .we(we), .addr(addr), .wdata(payload), .rdata(rdata)
  );

  // decode, pointer update, transmit FSM and overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
      ovf    <= 1'b0;
      state  <= TX_IDLE;
    end else begin
      if (bus.rx_valid) begin
        case (cmd)
          CMD_WR_ADDR: wr_ptr <= payload[ADDR_W-1:0];
          CMD_WR_DATA: if (AUTO_INC) wr_ptr <= wr_ptr + 1'b1;
          CMD_RD_ADDR: rd_ptr <= payload[ADDR_W-1:0];
          CMD_RD_DATA: if (AUTO_INC && rd_fire) rd_ptr <= rd_ptr + 1'b1;
          default: ;
        endcase
      end

      case (state)
        TX_IDLE: if (rd_fire) begin
          dout  <= rdata;
          state <= TX_HOLD;
        end
        TX_HOLD: if (rd_fire) begin
          dout  <= rdata;
        end else if (bus.tx_ready) begin
          state <= TX_IDLE;
        end
        default: state <= TX_IDLE;
      endcase

      if (rd_req && !rd_fire) ovf <= 1'b1;
      else if (bus.ovf_clr)   ovf <= 1'b0;
    end
  end

  assign bus.dout     = dout;
  assign bus.tx_valid = (state == TX_HOLD);
  assign bus.ovf      = ovf;
  assign bus.wr_ptr   = wr_ptr;
  assign bus.rd_ptr   = rd_ptr;
endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed vector bench: full-depth DUT for burst/handshake/reset, 200-word DUT for range checks.
module tb_spi_ram_burst;
  import spi_ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spi_ram_burst_if #(.DATA_W(8), .ADDR_W(8)) bus   ();
  spi_ram_burst_if #(.DATA_W(8), .ADDR_W(8)) bus_s ();

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1'b1))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1'b1))
    u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  typedef struct {
    string      name;
    logic       rv;
    logic [1:0] cmd;
    logic [7:0] pay;
    logic       trdy;
    logic       clr;
    logic [7:0] e_dout;
    logic       e_tv;
    logic       e_ovf;
    logic [7:0] e_wp;
    logic [7:0] e_rp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic rv, logic [1:0] c, logic [7:0] p, logic tr, logic cl,
                              logic [7:0] d, logic tv, logic ov, logic [7:0] wp, logic [7:0] rp);
    vec_t v;
    v.name = n; v.rv = rv; v.cmd = c; v.pay = p; v.trdy = tr; v.clr = cl;
    v.e_dout = d; v.e_tv = tv; v.e_ovf = ov; v.e_wp = wp; v.e_rp = rp;
    return v;
  endfunction

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(logic rv, logic [1:0] c, logic [7:0] p, logic tr, logic cl);
    bus.rx_valid = rv;
    bus.din      = {c, p};
    bus.tx_ready = tr;
    bus.ovf_clr  = cl;
  endtask

  function automatic logic [63:0] snap();
    return {29'd0, bus.dout, bus.tx_valid, bus.ovf, bus.wr_ptr, bus.rd_ptr, 10'd0};
  endfunction

  // one command to the 200-word DUT, always ready on the transmit side
  task automatic sd(logic [1:0] c, logic [7:0] p);
    bus_s.rx_valid = 1'b1;
    bus_s.din      = {c, p};
    @(negedge clk);
    bus_s.rx_valid = 1'b0;
  endtask

  initial begin
    drive(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    bus_s.rx_valid = 1'b0; bus_s.din = '0; bus_s.tx_ready = 1'b1; bus_s.ovf_clr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_main", snap(), {29'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 10'd0});
    chk("reset_small", {bus_s.dout, bus_s.tx_valid, bus_s.ovf, bus_s.wr_ptr, bus_s.rd_ptr}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    //            name        rv  cmd    pay   tr cl  dout  tv ov  wp     rp
    vecs.push_back(mk("t1_wa",   1, 2'b00, 8'h10, 1, 0, 8'h00, 0, 0, 8'h10, 8'h00));
    vecs.push_back(mk("t1_wd0",  1, 2'b01, 8'hA1, 1, 0, 8'h00, 0, 0, 8'h11, 8'h00));
    vecs.push_back(mk("t1_wd1",  1, 2'b01, 8'hB2, 1, 0, 8'h00, 0, 0, 8'h12, 8'h00));
    vecs.push_back(mk("t1_wd2",  1, 2'b01, 8'hC3, 1, 0, 8'h00, 0, 0, 8'h13, 8'h00));
    vecs.push_back(mk("t1_ra",   1, 2'b10, 8'h10, 1, 0, 8'h00, 0, 0, 8'h13, 8'h10));
    vecs.push_back(mk("t1_rd0",  1, 2'b11, 8'h00, 1, 0, 8'hA1, 1, 0, 8'h13, 8'h11));
    vecs.push_back(mk("t1_rd1",  1, 2'b11, 8'h00, 1, 0, 8'hB2, 1, 0, 8'h13, 8'h12));
    vecs.push_back(mk("t1_rd2",  1, 2'b11, 8'h00, 1, 0, 8'hC3, 1, 0, 8'h13, 8'h13));
    vecs.push_back(mk("t1_idle", 0, 2'b00, 8'h00, 1, 0, 8'hC3, 0, 0, 8'h13, 8'h13));
    vecs.push_back(mk("t2_wa",   1, 2'b00, 8'hFF, 1, 0, 8'hC3, 0, 0, 8'hFF, 8'h13));
    vecs.push_back(mk("t2_wd0",  1, 2'b01, 8'h11, 1, 0, 8'hC3, 0, 0, 8'h00, 8'h13));
    vecs.push_back(mk("t2_wd1",  1, 2'b01, 8'h22, 1, 0, 8'hC3, 0, 0, 8'h01, 8'h13));
    vecs.push_back(mk("t2_ra",   1, 2'b10, 8'hFF, 1, 0, 8'hC3, 0, 0, 8'h01, 8'hFF));
    vecs.push_back(mk("t4_rd0",  1, 2'b11, 8'h00, 1, 0, 8'h11, 1, 0, 8'h01, 8'h00));
    vecs.push_back(mk("t4_rd1",  1, 2'b11, 8'h00, 1, 0, 8'h22, 1, 0, 8'h01, 8'h01));
    vecs.push_back(mk("t4_idle", 0, 2'b00, 8'h00, 1, 0, 8'h22, 0, 0, 8'h01, 8'h01));
    vecs.push_back(mk("t3_ra",   1, 2'b10, 8'h10, 0, 0, 8'h22, 0, 0, 8'h01, 8'h10));
    vecs.push_back(mk("t3_rd",   1, 2'b11, 8'h00, 0, 0, 8'hA1, 1, 0, 8'h01, 8'h11));
    vecs.push_back(mk("t3_st0",  0, 2'b00, 8'h00, 0, 0, 8'hA1, 1, 0, 8'h01, 8'h11));
    vecs.push_back(mk("t3_st1",  0, 2'b00, 8'h00, 0, 0, 8'hA1, 1, 0, 8'h01, 8'h11));
    vecs.push_back(mk("t3_st2",  0, 2'b00, 8'h00, 0, 0, 8'hA1, 1, 0, 8'h01, 8'h11));
    vecs.push_back(mk("t3_drop", 1, 2'b11, 8'h00, 0, 0, 8'hA1, 1, 1, 8'h01, 8'h11));
    vecs.push_back(mk("t3_held", 0, 2'b00, 8'h00, 0, 0, 8'hA1, 1, 1, 8'h01, 8'h11));
    vecs.push_back(mk("t3_take", 0, 2'b00, 8'h00, 1, 0, 8'hA1, 0, 1, 8'h01, 8'h11));
    vecs.push_back(mk("ovf_clr", 0, 2'b00, 8'h00, 1, 1, 8'hA1, 0, 0, 8'h01, 8'h11));
    vecs.push_back(mk("idle_rd", 1, 2'b11, 8'h00, 0, 0, 8'hB2, 1, 0, 8'h01, 8'h12));
    vecs.push_back(mk("set_pri", 1, 2'b11, 8'h00, 0, 1, 8'hB2, 1, 1, 8'h01, 8'h12));
    vecs.push_back(mk("b2b_ovf", 1, 2'b11, 8'h00, 1, 0, 8'hC3, 1, 1, 8'h01, 8'h13));
    vecs.push_back(mk("clr2",    0, 2'b00, 8'h00, 1, 1, 8'hC3, 0, 0, 8'h01, 8'h13));
    vecs.push_back(mk("rv_low",  0, 2'b00, 8'h55, 1, 0, 8'hC3, 0, 0, 8'h01, 8'h13));

    foreach (vecs[i]) begin
      drive(vecs[i].rv, vecs[i].cmd, vecs[i].pay, vecs[i].trdy, vecs[i].clr);
      @(negedge clk);
      chk(vecs[i].name, snap(),
          {29'd0, vecs[i].e_dout, vecs[i].e_tv, vecs[i].e_ovf, vecs[i].e_wp, vecs[i].e_rp, 10'd0});
    end
    drive(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);

    // range handling on the 200-word instance
    sd(CMD_WR_ADDR, 8'h00); sd(CMD_WR_DATA, 8'h77);
    sd(CMD_WR_ADDR, 8'hC7); sd(CMD_WR_DATA, 8'h99); sd(CMD_WR_DATA, 8'h55);
    chk("t5_wp_c9", 64'(bus_s.wr_ptr), 64'h00C9);
    sd(CMD_WR_ADDR, 8'hD0); sd(CMD_WR_DATA, 8'h55);
    chk("t5_wp_d1", 64'(bus_s.wr_ptr), 64'h00D1);
    sd(CMD_RD_ADDR, 8'hC7); sd(CMD_RD_DATA, 8'h00);
    chk("t5_last_word", {bus_s.tx_valid, bus_s.dout}, {1'b1, 8'h99});
    sd(CMD_RD_DATA, 8'h00);
    chk("t5_c8_zero", {bus_s.dout, bus_s.rd_ptr}, {8'h00, 8'hC9});
    sd(CMD_RD_ADDR, 8'hD0); sd(CMD_RD_DATA, 8'h00);
    chk("t5_d0_zero", {bus_s.dout, bus_s.rd_ptr}, {8'h00, 8'hD1});
    sd(CMD_RD_ADDR, 8'h00); sd(CMD_RD_DATA, 8'h00);
    chk("t5_no_alias", 64'(bus_s.dout), 64'h77);

    // reset in the middle of a held, overrun burst
    drive(1'b1, CMD_RD_ADDR, 8'h10, 1'b0, 1'b0); @(negedge clk);
    drive(1'b1, CMD_RD_DATA, 8'h00, 1'b0, 1'b0); @(negedge clk);
    drive(1'b1, CMD_RD_DATA, 8'h00, 1'b0, 1'b0); @(negedge clk);
    chk("t6_pre", snap(), {29'd0, 8'hA1, 1'b1, 1'b1, 8'h01, 8'h11, 10'd0});
    drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_rst", snap(), {29'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 10'd0});
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, CMD_RD_ADDR, 8'h10, 1'b1, 1'b0); @(negedge clk);
    drive(1'b1, CMD_RD_DATA, 8'h00, 1'b1, 1'b0); @(negedge clk);
    chk("t6_keep_10", {bus.tx_valid, bus.dout}, {1'b1, 8'hA1});
    drive(1'b1, CMD_RD_ADDR, 8'hFF, 1'b1, 1'b0); @(negedge clk);
    drive(1'b1, CMD_RD_DATA, 8'h00, 1'b1, 1'b0); @(negedge clk);
    chk("t6_keep_ff", 64'(bus.dout), 64'h11);
    drive(1'b1, CMD_RD_DATA, 8'h00, 1'b1, 1'b0); @(negedge clk);
    chk("t6_keep_00", {bus.dout, bus.rd_ptr}, {8'h22, 8'h01});
    drive(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
